pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage: registered valid/ready/data with a main and a skid slot.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
`endif
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] main_r, main_s;
  logic [WIDTH-1:0] skid_r, skid_s;
  logic             out_valid_r, out_valid_s;
  logic             in_ready_r, in_ready_s;
  logic             in_hs_s;
  logic             out_hs_s;

  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;
  assign out_data  = main_r;

  // Handshake decode and next-state/payload selection; flush overrides everything but reset.
  always_comb begin
    in_hs_s     = in_valid & in_ready_r;
    out_hs_s    = out_valid_r & out_ready;
    state_s     = state_r;
    main_s      = main_r;
    skid_s      = skid_r;
    out_valid_s = out_valid_r;
    in_ready_s  = in_ready_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_hs_s) begin
          state_s = ST_BUSY;
          main_s  = in_data;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (in_hs_s && out_hs_s) begin
          main_s = in_data;
        end else if (in_hs_s) begin
          state_s = ST_FULL;
          skid_s  = in_data;
        end else if (out_hs_s) begin
          state_s = ST_EMPTY;
          main_s  = CLR_VALUE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path can move the state.
        if (out_hs_s) begin
          state_s = ST_BUSY;
          main_s  = skid_r;
          skid_s  = CLR_VALUE;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_EMPTY;
        main_s  = CLR_VALUE;
        skid_s  = CLR_VALUE;
      end
    endcase
    if (flush) begin
      state_s = ST_EMPTY;
      main_s  = CLR_VALUE;
      skid_s  = CLR_VALUE;
    end else begin
      state_s = state_s;
    end
    out_valid_s = (state_s != ST_EMPTY);
    in_ready_s  = (state_s != ST_FULL);
  end

  // State, payload and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= CLR_VALUE;
      skid_r      <= CLR_VALUE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  // Saturating counters; a flush only counts when it throws away a held entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush && out_valid_r && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid; counter checks compile in only with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int tests_run;
  int tests_failed;

  pipe_stage_skid #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests_run++; if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got %h exp 0", out_data); end
`ifdef PIPE_STAGE_PERF_EN
    tests_run++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
`endif
  endtask

  task automatic test_stream();
    logic [31:0] vec [3];
    vec[0] = 32'hDEADBEEF; vec[1] = 32'h00000001; vec[2] = 32'hA5A5A5A5;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vec[i];
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_data !== vec[i]) begin tests_failed++; $display("FAIL stream_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, vec[i]); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_ready_%0d got %b exp 1", i, in_ready); end
    end
    in_valid = 1'b0; in_data = 32'h0;
    tick();
    tests_run++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin tests_failed++; $display("FAIL stream_drain got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    tests_run++; if (out_data !== 32'h11 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_first got d=%h r=%b exp d=11 r=1", out_data, in_ready); end
    in_data = 32'h22;
    tick();
    tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11) begin tests_failed++; $display("FAIL bp_full got r=%b v=%b d=%h exp r=0 v=1 d=11", in_ready, out_valid, out_data); end
    in_data = 32'h99;
    tick();
    tests_run++; if (in_ready !== 1'b0 || out_data !== 32'h11) begin tests_failed++; $display("FAIL bp_hold got r=%b d=%h exp r=0 d=11", in_ready, out_data); end
`ifdef PIPE_STAGE_PERF_EN
    tests_run++; if (stall_cnt !== 16'd2) begin tests_failed++; $display("FAIL bp_stall_cnt got %0d exp 2", stall_cnt); end
`endif
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 32'h0;
    tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h22 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_second got v=%b d=%h r=%b exp v=1 d=22 r=1", out_valid, out_data, in_ready); end
    tick();
    tests_run++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin tests_failed++; $display("FAIL bp_empty got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
`ifdef PIPE_STAGE_PERF_EN
    tests_run++; if (stall_cnt !== 16'd2) begin tests_failed++; $display("FAIL bp_stall_final got %0d exp 2", stall_cnt); end
`endif
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h44;
    tick();
    in_data = 32'h55;
    tick();
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_setup got r=%b exp 0", in_ready); end
    flush = 1'b1; in_data = 32'h33;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    tests_run++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_clear got v=%b d=%h r=%b exp v=0 d=0 r=1", out_valid, out_data, in_ready); end
`ifdef PIPE_STAGE_PERF_EN
    tests_run++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd4) begin tests_failed++; $display("FAIL flush_counters got f=%0d s=%0d exp f=1 s=4", flush_cnt, stall_cnt); end
`endif
    out_ready = 1'b1;
    tick(); tick();
    tests_run++; if (out_valid !== 1'b0 || out_data === 32'h33) begin tests_failed++; $display("FAIL flush_no_33 got v=%b d=%h exp v=0", out_valid, out_data); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    tests_run++; if (flush_cnt !== 16'd1) begin tests_failed++; $display("FAIL flush_empty_cnt got %0d exp 1", flush_cnt); end
`endif
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h66;
    tick();
    in_data = 32'h77;
    tick();
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    tests_run++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_full got v=%b d=%h r=%b exp v=0 d=0 r=1", out_valid, out_data, in_ready); end
`ifdef PIPE_STAGE_PERF_EN
    tests_run++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin tests_failed++; $display("FAIL rst_full_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
`endif
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_full_after got v=%b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFFFFFF;
    tick();
    in_data = 32'h80000001;
    tick();
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    tests_run++; if (out_data !== 32'h80000001 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_skid got d=%h r=%b exp d=80000001 r=1", out_data, in_ready); end
    in_valid = 1'b1; in_data = 32'h12345678;
    tick();
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin tests_failed++; $display("FAIL b2b_pass got v=%b d=%h exp v=1 d=12345678", out_valid, out_data); end
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end got v=%b exp 0", out_valid); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_reset_full();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
